positron_argmax: RTL and testbench



---
 rtl/positron_pkg.sv | 33 +++
 rtl/posit_max_cmp.sv | 30 +++
 rtl/positron_argmax.sv | 121 ++++++++++++
 tb/tb_positron_argmax.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/positron_pkg.sv
// ============================================================================
// positron_pkg -- shared types and posit ordering helpers for positron blocks
// Rev 1.0
// ============================================================================
`default_nettype none

package positron_pkg;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } argmax_state_t;

  localparam int c_posit_max_w = 64;

  // Left-aligning both words keeps their signed order for any width up to 64.
  function automatic logic posit_gt(input logic [c_posit_max_w-1:0] a,
                                    input logic [c_posit_max_w-1:0] b,
                                    input int                       width);
    logic signed [c_posit_max_w-1:0] sa;
    logic signed [c_posit_max_w-1:0] sb;
    sa = $signed(a << (c_posit_max_w - width));
    sb = $signed(b << (c_posit_max_w - width));
    return sa > sb;
  endfunction

  function automatic logic [c_posit_max_w-1:0] posit_nar(input int width);
    return c_posit_max_w'(1) << (width - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/posit_max_cmp.sv
// ============================================================================
// posit_max_cmp -- keeps the larger of a candidate posit and the running max
// Rev 1.0
// ============================================================================
`default_nettype none

module posit_max_cmp
  import positron_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int IDX_W = 4
) (
  input  logic [WIDTH-1:0] cand_i,
  input  logic [IDX_W-1:0] cand_idx_i,
  input  logic [WIDTH-1:0] max_i,
  input  logic [IDX_W-1:0] idx_i,
  output logic [WIDTH-1:0] max_o,
  output logic [IDX_W-1:0] idx_o
);

  logic w_gt;

  // Strictly-greater only, so an equal candidate never displaces a lower index.
  assign w_gt  = posit_gt(c_posit_max_w'(cand_i), c_posit_max_w'(max_i), WIDTH);
  assign max_o = w_gt ? cand_i     : max_i;
  assign idx_o = w_gt ? cand_idx_i : idx_i;

endmodule

`default_nettype wire

// File: rtl/positron_argmax.sv
// ============================================================================
// positron_argmax -- per-frame argmax over the last layer's posit stream
// Rev 1.0
// ============================================================================
`default_nettype none

module positron_argmax
  import positron_pkg::*;
#(
  parameter int NB_CLASSES  = 10,
  parameter int POSIT_WIDTH = 16,
  parameter int POSIT_ES    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  output logic                          rtr_o,
  input  logic                          rts_i,
  input  logic                          eow_i,
  input  logic [POSIT_WIDTH-1:0]        posit_i,
  input  logic                          rtr_i,
  output logic                          rts_o,
  output logic                          eow_o,
  output logic [$clog2(NB_CLASSES)-1:0] class_o,
  output logic [POSIT_WIDTH-1:0]        max_posit_o
);

  localparam int                 c_idx_w   = $clog2(NB_CLASSES);
  localparam logic [c_idx_w-1:0] c_last_wc = c_idx_w'(NB_CLASSES - 1);

  // The exponent size never affects ordering; only the legal range is checked.
  if (NB_CLASSES < 2 || POSIT_ES < 0 || POSIT_ES > POSIT_WIDTH - 2) begin : g_param_illegal
  end

  argmax_state_t            state_q, state_d;
  logic [c_idx_w-1:0]       wc_q, wc_d;
  logic [POSIT_WIDTH-1:0]   max_q, max_d;
  logic [c_idx_w-1:0]       idx_q, idx_d;
  logic                     eow_q, eow_d;
  logic [POSIT_WIDTH-1:0]   w_cmp_max;
  logic [c_idx_w-1:0]       w_cmp_idx;
  logic                     w_accept;
  logic                     w_close;

  posit_max_cmp #(
    .WIDTH (POSIT_WIDTH),
    .IDX_W (c_idx_w)
  ) u_cmp (
    .cand_i     (posit_i),
    .cand_idx_i (wc_q),
    .max_i      (max_q),
    .idx_i      (idx_q),
    .max_o      (w_cmp_max),
    .idx_o      (w_cmp_idx)
  );

  assign w_accept = rts_i && (state_q == ACCUM);
  assign w_close  = (wc_q == c_last_wc) || eow_i;

  always_comb begin
    state_d = state_q;
    wc_d    = wc_q;
    max_d   = max_q;
    idx_d   = idx_q;
    eow_d   = eow_q;
    rtr_o   = 1'b0;
    rts_o   = 1'b0;
    case (state_q)
      ACCUM: begin
        rtr_o = 1'b1;
        if (w_accept) begin
          // First word of a frame seeds the max regardless of stale contents.
          if (wc_q == '0) begin
            max_d = posit_i;
            idx_d = '0;
          end else begin
            max_d = w_cmp_max;
            idx_d = w_cmp_idx;
          end
          if (w_close) begin
            wc_d    = '0;
            eow_d   = eow_i;
            state_d = EMIT;
          end else begin
            wc_d = wc_q + c_idx_w'(1);
          end
        end
      end
      EMIT: begin
        rts_o = 1'b1;
        if (rtr_i) begin
          wc_d    = '0;
          state_d = ACCUM;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      wc_q    <= '0;
      max_q   <= '0;
      idx_q   <= '0;
      eow_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wc_q    <= wc_d;
      max_q   <= max_d;
      idx_q   <= idx_d;
      eow_q   <= eow_d;
    end
  end

  assign class_o     = idx_q;
  assign max_posit_o = max_q;
  assign eow_o       = eow_q;

endmodule

`default_nettype wire

// File: tb/tb_positron_argmax.sv
// ============================================================================
// tb_positron_argmax -- directed vectors, corner sequences and random stream
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_positron_argmax;

  localparam int NB = 10;
  localparam int W  = 16;
  localparam int IW = $clog2(NB);
  localparam int NF = 1000;

  logic          clk = 1'b0;
  logic          rst;
  logic          rtr_o;
  logic          rts_i;
  logic          eow_i;
  logic [W-1:0]  posit_i;
  logic          rtr_i;
  logic          rts_o;
  logic          eow_o;
  logic [IW-1:0] class_o;
  logic [W-1:0]  max_posit_o;

  positron_argmax #(
    .NB_CLASSES  (NB),
    .POSIT_WIDTH (W),
    .POSIT_ES    (0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rtr_o       (rtr_o),
    .rts_i       (rts_i),
    .eow_i       (eow_i),
    .posit_i     (posit_i),
    .rtr_i       (rtr_i),
    .rts_o       (rts_o),
    .eow_o       (eow_o),
    .class_o     (class_o),
    .max_posit_o (max_posit_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] w [NB];
    int           len;
    logic         eow;
    int           cls;
    logic [W-1:0] mx;
    logic         eo;
  } vec_t;

  typedef struct {
    int           cls;
    logic [W-1:0] mx;
    logic         eo;
  } res_t;

  int   errors = 0;
  int   checks = 0;
  bit   stuck  = 0;
  vec_t vt [8];
  res_t q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void ref_argmax(input logic [W-1:0] w [NB], input int len,
                                     output int cls, output logic [W-1:0] mx);
    cls = 0;
    mx  = w[0];
    for (int i = 1; i < len; i++)
      if ($signed(w[i]) > $signed(mx)) begin
        cls = i;
        mx  = w[i];
      end
  endfunction

  task automatic send_word(input logic [W-1:0] w, input logic e);
    bit acc;
    bit ok;
    ok = 0;
    if (stuck) return;
    rts_i   = 1'b1;
    posit_i = w;
    eow_i   = e;
    for (int n = 0; n < 200; n++) begin
      acc = rtr_o;
      @(posedge clk); #1;
      if (acc) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      stuck = 1;
      check("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic send_frame(input logic [W-1:0] w [NB], input int len, input logic e);
    for (int i = 0; i < len; i++) begin
      send_word(w[i], (i == len - 1) ? e : 1'b0);
      if (i < len - 1) check("early_rts", 32'(rts_o), 32'd0);
    end
    rts_i = 1'b0;
    eow_i = 1'b0;
  endtask

  task automatic check_result(input string tag, input int cls, input logic [W-1:0] mx,
                              input logic eo);
    check({tag, "_rts"},   32'(rts_o),       32'd1);
    check({tag, "_class"}, 32'(class_o),     32'(cls));
    check({tag, "_max"},   32'(max_posit_o), 32'(mx));
    check({tag, "_eow"},   32'(eow_o),       32'(eo));
  endtask

  initial begin
    logic [W-1:0] bp1 [NB];
    logic [W-1:0] bp2 [NB];
    logic [W-1:0] rf  [NB];
    int           mcls;
    logic [W-1:0] mmx;

    vt[0].w = '{16'h0100, 16'h0200, 16'h0300, 16'h0400, 16'h0500,
                16'h0600, 16'h0700, 16'h0800, 16'h0900, 16'h0A00};
    vt[0].len = 10; vt[0].eow = 0; vt[0].cls = 9; vt[0].mx = 16'h0A00; vt[0].eo = 0;
    vt[1].w = '{16'h8000, 16'hF000, 16'h4000, 16'h4000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vt[1].len = 10; vt[1].eow = 0; vt[1].cls = 2; vt[1].mx = 16'h4000; vt[1].eo = 0;
    vt[2].w = '{16'h1000, 16'h3000, 16'h2000, 16'h0500, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vt[2].len = 4;  vt[2].eow = 1; vt[2].cls = 1; vt[2].mx = 16'h3000; vt[2].eo = 1;
    vt[3].w = '{default: 16'h8000};
    vt[3].len = 10; vt[3].eow = 1; vt[3].cls = 0; vt[3].mx = 16'h8000; vt[3].eo = 1;
    vt[4].w = '{16'h7FFF, 16'h7FFE, 16'h0000, 16'h8000, 16'hFFFF,
                16'h0001, 16'h0002, 16'h0003, 16'h0004, 16'h0005};
    vt[4].len = 10; vt[4].eow = 0; vt[4].cls = 0; vt[4].mx = 16'h7FFF; vt[4].eo = 0;
    vt[5].w = '{16'hFFFF, 16'h7000, 16'h7000, 16'h7000, 16'h7000,
                16'h7000, 16'h7000, 16'h7000, 16'h7000, 16'h7000};
    vt[5].len = 1;  vt[5].eow = 1; vt[5].cls = 0; vt[5].mx = 16'hFFFF; vt[5].eo = 1;
    vt[6].w = '{16'hFFF0, 16'hFFF1, 16'hFFF2, 16'hFFF3, 16'hFFF4,
                16'hFFF5, 16'hFFF6, 16'hFFF7, 16'hFFF8, 16'hFFF9};
    vt[6].len = 10; vt[6].eow = 0; vt[6].cls = 9; vt[6].mx = 16'hFFF9; vt[6].eo = 0;
    vt[7].w = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h0000,
                16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
    vt[7].len = 2;  vt[7].eow = 1; vt[7].cls = 0; vt[7].mx = 16'h0001; vt[7].eo = 1;

    bp1 = '{16'h0300, 16'h0100, 16'h0900, 16'h0200, 16'h0900,
            16'h0000, 16'h0400, 16'h0100, 16'h0500, 16'h0600};
    bp2 = '{16'h8000, 16'h0001, 16'hFFFF, 16'h0002, 16'h0002,
            16'h7000, 16'h6FFF, 16'h0000, 16'h7000, 16'h0003};
    rf  = '{16'h0010, 16'h0020, 16'h0050, 16'h0030, 16'h0040,
            16'h0010, 16'h0000, 16'h0060, 16'h0020, 16'h0005};

    rst = 1'b1; rts_i = 1'b0; eow_i = 1'b0; posit_i = '0; rtr_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_rtr",   32'(rtr_o),       32'd1);
    check("reset_rts",   32'(rts_o),       32'd0);
    check("reset_eow",   32'(eow_o),       32'd0);
    check("reset_class", 32'(class_o),     32'd0);
    check("reset_max",   32'(max_posit_o), 32'd0);

    // Directed frames: result must be visible right after the closing accept.
    rtr_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      send_frame(vt[i].w, vt[i].len, vt[i].eow);
      check_result($sformatf("vec%0d", i), vt[i].cls, vt[i].mx, vt[i].eo);
      @(posedge clk); #1;
      check($sformatf("vec%0d_rts_drop", i), 32'(rts_o), 32'd0);
      check($sformatf("vec%0d_reopen", i),   32'(rtr_o), 32'd1);
    end

    // Backpressure: upstream holds the next word while the result waits.
    rtr_i = 1'b0;
    send_frame(bp1, 10, 1'b0);
    rts_i = 1'b1; posit_i = bp2[0]; eow_i = 1'b0;
    check_result("bp1", 2, 16'h0900, 1'b0);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_hold_rtr", 32'(rtr_o), 32'd0);
      check_result("bp_hold", 2, 16'h0900, 1'b0);
    end
    rtr_i = 1'b1;
    send_frame(bp2, 10, 1'b0);
    ref_argmax(bp2, 10, mcls, mmx);
    check_result("bp2", mcls, mmx, 1'b0);
    @(posedge clk); #1;

    // Reset mid-frame, with a word offered in the reset cycle.
    for (int i = 0; i < 6; i++) send_word(16'h7000 + 16'(i * 16'h0100), 1'b0);
    rts_i = 1'b1; posit_i = 16'h7FFF; eow_i = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; rts_i = 1'b0;
    check("midrst_rtr",   32'(rtr_o),       32'd1);
    check("midrst_rts",   32'(rts_o),       32'd0);
    check("midrst_eow",   32'(eow_o),       32'd0);
    check("midrst_class", 32'(class_o),     32'd0);
    check("midrst_max",   32'(max_posit_o), 32'd0);
    send_frame(rf, 10, 1'b0);
    check_result("postrst", 7, 16'h0060, 1'b0);
    @(posedge clk); #1;

    // Random stream with independent producer and consumer.
    fork
      begin : producer
        for (int f = 0; f < NF && !stuck; f++) begin
          logic [W-1:0] fw [NB];
          int           len;
          logic         e;
          res_t         r;
          len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 9)) : NB;
          e   = (len < NB) ? 1'b1 : 1'($urandom_range(0, 1));
          for (int i = 0; i < NB; i++) begin
            case ($urandom_range(0, 7))
              0:       fw[i] = W'(positron_pkg::posit_nar(W));
              1, 2:    fw[i] = W'($urandom_range(0, 3));
              default: fw[i] = W'($urandom);
            endcase
          end
          ref_argmax(fw, len, r.cls, r.mx);
          r.eo = e;
          q.push_back(r);
          for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) begin
              rts_i = 1'b0;
              repeat ($urandom_range(1, 2)) @(posedge clk);
              #1;
            end
            send_word(fw[i], (i == len - 1) ? e : 1'b0);
          end
          rts_i = 1'b0;
          eow_i = 1'b0;
        end
      end
      begin : consumer
        int           got;
        int           cyc;
        bit           pv;
        logic [IW-1:0] pc;
        logic [W-1:0] pm;
        logic         pe;
        res_t         r;
        got = 0; cyc = 0; pv = 0; pc = '0; pm = '0; pe = 1'b0;
        while (got < NF && cyc < 40000 && !stuck) begin
          check("rnd_exclusive", 32'(rtr_o & rts_o), 32'd0);
          if (pv) check_result("rnd_hold", int'(pc), pm, pe);
          rtr_i = ($urandom_range(0, 3) != 0);
          if (rts_o && rtr_i) begin
            if (q.size() == 0) begin
              check("rnd_spurious", 32'd1, 32'd0);
            end else begin
              r = q.pop_front();
              check("rnd_class", 32'(class_o),     32'(r.cls));
              check("rnd_max",   32'(max_posit_o), 32'(r.mx));
              check("rnd_eow",   32'(eow_o),       32'(r.eo));
            end
            got++;
          end
          pv = rts_o && !rtr_i;
          pc = class_o; pm = max_posit_o; pe = eow_o;
          @(posedge clk); #1;
          cyc++;
        end
        check("rnd_count", 32'(got), 32'(NF));
      end
    join
    check("rnd_leftover", 32'(q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
